// File: rtl/colour_map_arbiter_pkg.sv
// rtl/colour_map_arbiter_pkg.sv - shared types for the colour_map arbiter (types_pkg)
package types_pkg;

  localparam int NUM_REQ = 2;

  typedef logic [3:0] flags_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/colour_map_arbiter_if.sv
// rtl/colour_map_arbiter_if.sv - two-requester beat bus plus downstream colour_map port
interface colour_map_arbiter_if;
  import types_pkg::*;

  logic [NUM_REQ-1:0] s_valid;
  logic [NUM_REQ-1:0] s_ready;
  logic [NUM_REQ-1:0] s_last;
  logic [10:0]        s0_hue;
  logic [10:0]        s1_hue;
  logic [8:0]         s0_log_mag;
  logic [8:0]         s1_log_mag;
  flags_t             s0_flags;
  flags_t             s1_flags;

  logic               m_valid;
  logic               m_ready;
  logic [10:0]        m_hue;
  logic [8:0]         m_log_mag;
  flags_t             m_flags;
  logic               m_last;
  logic               m_src;

  modport slave (
    input  s_valid, s_last, s0_hue, s1_hue, s0_log_mag, s1_log_mag, s0_flags, s1_flags,
    input  m_ready,
    output s_ready,
    output m_valid, m_hue, m_log_mag, m_flags, m_last, m_src
  );

  modport master (
    output s_valid, s_last, s0_hue, s1_hue, s0_log_mag, s1_log_mag, s0_flags, s1_flags,
    output m_ready,
    input  s_ready,
    input  m_valid, m_hue, m_log_mag, m_flags, m_last, m_src
  );

endinterface

// File: rtl/colour_map_arbiter.sv
// rtl/colour_map_arbiter.sv - packet-atomic round-robin arbiter feeding colour_map
// Optional stalled-packet watchdog: COLOUR_ARB_TIMEOUT_EN
module colour_map_arbiter
  import types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  colour_map_arbiter_if.slave  bus,
  output logic                 timeout_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..65535");
  end

  arb_state_t  state_q, state_d;
  logic        rr_q, rr_d;
  logic        m_valid_q, m_valid_d;
  logic [10:0] m_hue_q, m_hue_d;
  logic [8:0]  m_log_mag_q, m_log_mag_d;
  flags_t      m_flags_q, m_flags_d;
  logic        m_last_q, m_last_d;
  logic        m_src_q, m_src_d;

  logic               load;
  logic               sel;
  logic               granted;
  logic               accept;
  logic [NUM_REQ-1:0] s_ready_c;

`ifdef COLOUR_ARB_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    load    = !m_valid_q || bus.m_ready;
    sel     = rr_q;
    granted = 1'b0;
    case (state_q)
      IDLE: begin
        granted = |bus.s_valid;
        sel     = bus.s_valid[rr_q] ? rr_q : ~rr_q;
      end
      GRANT0: begin
        granted = 1'b1;
        sel     = 1'b0;
      end
      GRANT1: begin
        granted = 1'b1;
        sel     = 1'b1;
      end
      default: begin
        granted = 1'b0;
        sel     = rr_q;
      end
    endcase

    // reset gates s_ready directly so requesters see 0 while reset is held
    s_ready_c = '0;
    if (granted && load && !reset) begin
      s_ready_c[sel] = 1'b1;
    end
    accept = |(bus.s_valid & s_ready_c);

    m_valid_d   = m_valid_q;
    m_hue_d     = m_hue_q;
    m_log_mag_d = m_log_mag_q;
    m_flags_d   = m_flags_q;
    m_last_d    = m_last_q;
    m_src_d     = m_src_q;
    if (accept) begin
      m_valid_d   = 1'b1;
      m_hue_d     = sel ? bus.s1_hue     : bus.s0_hue;
      m_log_mag_d = sel ? bus.s1_log_mag : bus.s0_log_mag;
      m_flags_d   = sel ? bus.s1_flags   : bus.s0_flags;
      m_last_d    = bus.s_last[sel];
      m_src_d     = sel;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end

    state_d = state_q;
    rr_d    = rr_q;
    if (accept && bus.s_last[sel]) begin
      state_d = IDLE;
      rr_d    = ~sel;
    end else if (accept && state_q == IDLE) begin
      state_d = sel ? GRANT1 : GRANT0;
    end

`ifdef COLOUR_ARB_TIMEOUT_EN
    wdog_d = wdog_q;
    err_d  = err_q;
    if (state_q == IDLE || accept || bus.s_valid[sel]) begin
      wdog_d = '0;
    end else if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) begin
      // truncated packet is dropped without a closing m_last
      wdog_d  = '0;
      state_d = IDLE;
      rr_d    = ~sel;
      err_d   = 1'b1;
    end else begin
      wdog_d = wdog_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      m_valid_q   <= 1'b0;
      m_hue_q     <= '0;
      m_log_mag_q <= '0;
      m_flags_q   <= '0;
      m_last_q    <= 1'b0;
      m_src_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      m_valid_q   <= m_valid_d;
      m_hue_q     <= m_hue_d;
      m_log_mag_q <= m_log_mag_d;
      m_flags_q   <= m_flags_d;
      m_last_q    <= m_last_d;
      m_src_q     <= m_src_d;
    end
  end

`ifdef COLOUR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign bus.s_ready   = s_ready_c;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_hue     = m_hue_q;
  assign bus.m_log_mag = m_log_mag_q;
  assign bus.m_flags   = m_flags_q;
  assign bus.m_last    = m_last_q;
  assign bus.m_src     = m_src_q;

endmodule

// File: tb/tb_colour_map_arbiter.sv
// tb/tb_colour_map_arbiter.sv - directed self-checking bench for colour_map_arbiter
module tb_colour_map_arbiter;
  import types_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic timeout_err;
  int   n_assert = 0;
  int   n_fail   = 0;

  colour_map_arbiter_if bus ();

  colour_map_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk_rdy(input string tag, input logic [1:0] exp);
    n_assert++;
    assert (bus.s_ready === exp) else begin
      n_fail++;
      $error("FAIL %s: s_ready observed %b expected %b", tag, bus.s_ready, exp);
    end
  endtask

  task automatic chk_m(input string tag, input logic v, input logic [10:0] h,
                       input logic l, input logic s);
    logic [13:0] obs;
    logic [13:0] exp;
    obs = {bus.m_valid, bus.m_hue, bus.m_last, bus.m_src};
    exp = {v, h, l, s};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: {valid,hue,last,src} observed %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
             tag, obs[13], obs[12:2], obs[1], obs[0], v, h, l, s);
    end
  endtask

  task automatic chk_side(input string tag, input logic [8:0] mag, input flags_t fl);
    n_assert++;
    assert ({bus.m_log_mag, bus.m_flags} === {mag, fl}) else begin
      n_fail++;
      $error("FAIL %s: log_mag/flags observed %h/%h expected %h/%h",
             tag, bus.m_log_mag, bus.m_flags, mag, fl);
    end
  endtask

  task automatic chk_err(input string tag, input logic exp);
    n_assert++;
    assert (timeout_err === exp) else begin
      n_fail++;
      $error("FAIL %s: timeout_err observed %b expected %b", tag, timeout_err, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [10:0] h0, input logic l0,
                       input logic [10:0] h1, input logic l1);
    bus.s_valid = v;
    bus.s0_hue  = h0;
    bus.s1_hue  = h1;
    bus.s_last  = {l1, l0};
  endtask

  // inputs are applied 1 ns after the edge; s_ready sampled mid-cycle, outputs 1 ns after the next edge
  task automatic step(input string tag, input logic [1:0] exp_rdy);
    #3;
    chk_rdy(tag, exp_rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    bus.m_ready    = 1'b1;
    bus.s0_log_mag = 9'h011;
    bus.s1_log_mag = 9'h1f0;
    bus.s0_flags   = 4'ha;
    bus.s1_flags   = 4'h5;
    drive(2'b11, 11'd100, 1'b0, 11'd200, 1'b0);
    #2;
    chk_m("reset_m", 1'b0, 11'd0, 1'b0, 1'b0);
    chk_side("reset_side", 9'h000, 4'h0);
    chk_rdy("reset_rdy", 2'b00);
    chk_err("reset_err", 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    drive(2'b11, 11'd100, 1'b0, 11'd200, 1'b0);
    step("rdy_b1", 2'b01);
    chk_m("b1", 1'b1, 11'd100, 1'b0, 1'b0);
    chk_side("b1_side", 9'h011, 4'ha);
    drive(2'b11, 11'd101, 1'b0, 11'd200, 1'b0);
    step("rdy_b2", 2'b01);
    chk_m("b2", 1'b1, 11'd101, 1'b0, 1'b0);
    drive(2'b11, 11'd102, 1'b1, 11'd200, 1'b0);
    step("rdy_b3", 2'b01);
    chk_m("b3", 1'b1, 11'd102, 1'b1, 1'b0);
    drive(2'b11, 11'd103, 1'b1, 11'd200, 1'b0);
    step("rdy_b4", 2'b10);
    chk_m("b4", 1'b1, 11'd200, 1'b0, 1'b1);
    chk_side("b4_side", 9'h1f0, 4'h5);
    drive(2'b11, 11'd103, 1'b1, 11'd201, 1'b0);
    step("r0_blocked_b5", 2'b10);
    chk_m("b5", 1'b1, 11'd201, 1'b0, 1'b1);
    drive(2'b11, 11'd103, 1'b1, 11'd202, 1'b1);
    step("r0_blocked_b6", 2'b10);
    chk_m("b6", 1'b1, 11'd202, 1'b1, 1'b1);

    drive(2'b11, 11'd103, 1'b1, 11'd203, 1'b1);
    step("rdy_r0_after_r1", 2'b01);
    chk_m("single_r0", 1'b1, 11'd103, 1'b1, 1'b0);
    drive(2'b11, 11'd104, 1'b1, 11'd203, 1'b1);
    step("rdy_rr_toggled", 2'b10);
    chk_m("single_r1", 1'b1, 11'd203, 1'b1, 1'b1);

    drive(2'b01, 11'd1200, 1'b0, 11'd0, 1'b0);
    step("rdy_stall_first", 2'b01);
    chk_m("stall_first", 1'b1, 11'd1200, 1'b0, 1'b0);
    bus.m_ready = 1'b0;
    drive(2'b01, 11'd1201, 1'b1, 11'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("rdy_stalled", 2'b00);
      chk_m("stall_hold", 1'b1, 11'd1200, 1'b0, 1'b0);
    end
    bus.m_ready = 1'b1;
    step("rdy_stall_release", 2'b01);
    chk_m("stall_next", 1'b1, 11'd1201, 1'b1, 1'b0);
    drive(2'b00, 11'd0, 1'b0, 11'd0, 1'b0);
    step("rdy_idle_empty", 2'b00);
    chk_m("drain", 1'b0, 11'd1201, 1'b1, 1'b0);

    drive(2'b10, 11'd0, 1'b0, 11'd2047, 1'b1);
    step("rdy_hue_max", 2'b10);
    chk_m("hue_max", 1'b1, 11'd2047, 1'b1, 1'b1);

    drive(2'b01, 11'd5, 1'b0, 11'd0, 1'b0);
    step("rdy_wd_start", 2'b01);
    chk_m("wd_start", 1'b1, 11'd5, 1'b0, 1'b0);
    drive(2'b10, 11'd5, 1'b0, 11'd300, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step("rdy_wd_stall", 2'b01);
    end
    chk_m("wd_no_last", 1'b0, 11'd5, 1'b0, 1'b0);
`ifdef COLOUR_ARB_TIMEOUT_EN
    chk_err("wd_err_set", 1'b1);
    step("rdy_wd_regrant", 2'b10);
    chk_m("wd_r1", 1'b1, 11'd300, 1'b1, 1'b1);
    chk_err("wd_err_sticky", 1'b1);
`else
    chk_err("wd_err_tied", 1'b0);
    step("rdy_wd_hold", 2'b01);
    drive(2'b01, 11'd6, 1'b1, 11'd0, 1'b0);
    step("rdy_wd_resume", 2'b01);
    chk_m("wd_resume", 1'b1, 11'd6, 1'b1, 1'b0);
`endif

    drive(2'b11, 11'd7, 1'b0, 11'd301, 1'b0);
`ifdef COLOUR_ARB_TIMEOUT_EN
    step("rdy_pre_reset", 2'b01);
    chk_m("pre_reset", 1'b1, 11'd7, 1'b0, 1'b0);
`else
    step("rdy_pre_reset", 2'b10);
    chk_m("pre_reset", 1'b1, 11'd301, 1'b0, 1'b1);
`endif
    #2;
    reset = 1'b1;
    #1;
    chk_m("async_reset_m", 1'b0, 11'd0, 1'b0, 1'b0);
    chk_side("async_reset_side", 9'h000, 4'h0);
    chk_rdy("async_reset_rdy", 2'b00);
    chk_err("async_reset_err", 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(2'b11, 11'd8, 1'b1, 11'd302, 1'b1);
    step("rdy_post_reset", 2'b01);
    chk_m("post_reset", 1'b1, 11'd8, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
